// File: rtl/fifo_rd_ptr_ctrl_if.sv
// Read-side bus of the dual-clock FIFO: write-pointer input, consumer handshake,
// RAM address and status. master = consumer/write-side view, slave = controller.
interface fifo_rd_ptr_ctrl_if #(
   parameter int unsigned addr_width = 5
);
   logic [addr_width:0]   wr_ptr_gray;
   logic                  rd_en;
   logic [addr_width-1:0] rd_addr;
   logic                  rd_valid;
   logic                  empty;
   logic [addr_width:0]   rd_count;
   logic                  underflow;
   logic [addr_width:0]   rd_ptr_gray;

   modport master (
      output wr_ptr_gray, rd_en,
      input  rd_addr, rd_valid, empty, rd_count, underflow, rd_ptr_gray
   );

   modport slave (
      input  wr_ptr_gray, rd_en,
      output rd_addr, rd_valid, empty, rd_count, underflow, rd_ptr_gray
   );
endinterface

// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-domain pointer controller for the dual-clock FIFO: write-pointer sync,
// Gray/binary conversion, read pointer ownership, empty/occupancy/underflow.
module fifo_rd_ptr_ctrl #(
   parameter int unsigned addr_width = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   fifo_rd_ptr_ctrl_if.slave   bus
);
   localparam int unsigned PW = addr_width + 1;

   logic [PW-1:0] r_wq1;
   logic [PW-1:0] r_wq2;
   logic [PW-1:0] r_rd_bin;
   logic [PW-1:0] r_rd_gray;
   logic [PW-1:0] r_count;
   logic          r_empty;
   logic          r_valid;
   logic          r_underflow;

   logic [PW-1:0] w_wr_bin;
   logic [PW-1:0] w_rd_bin_next;
   logic [PW-1:0] w_rd_gray_next;
   logic          w_acc;

   // Synced write pointer to binary, accept decision, next read pointer
   always_comb begin
      w_wr_bin = '0;
      for (int unsigned i = 0; i < PW; i++) begin
         w_wr_bin[i] = ^(r_wq2 >> i);
      end
      w_acc          = bus.rd_en & ~r_empty;
      w_rd_bin_next  = r_rd_bin + PW'(w_acc);
      w_rd_gray_next = w_rd_bin_next ^ (w_rd_bin_next >> 1);
   end

   // Empty compares against the pre-edge synced pointer, so writes appear one edge after wq2
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wq1       <= '0;
         r_wq2       <= '0;
         r_rd_bin    <= '0;
         r_rd_gray   <= '0;
         r_count     <= '0;
         r_empty     <= 1'b1;
         r_valid     <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_wq1       <= bus.wr_ptr_gray;
         r_wq2       <= r_wq1;
         r_rd_bin    <= w_rd_bin_next;
         r_rd_gray   <= w_rd_gray_next;
         r_count     <= w_wr_bin - w_rd_bin_next;
         r_empty     <= (w_rd_gray_next == r_wq2);
         r_valid     <= w_acc;
         r_underflow <= bus.rd_en & r_empty;
      end
   end

   assign bus.rd_addr     = r_rd_bin[addr_width-1:0];
   assign bus.rd_ptr_gray = r_rd_gray;
   assign bus.rd_count    = r_count;
   assign bus.empty       = r_empty;
   assign bus.rd_valid    = r_valid;
   assign bus.underflow   = r_underflow;

endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// Bench for fifo_rd_ptr_ctrl: directed scenarios plus random traffic against an
// occupancy-counting reference model.
module tb_fifo_rd_ptr_ctrl;
   localparam int unsigned AW = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   fifo_rd_ptr_ctrl_if #(.addr_width(AW)) bus ();

   fifo_rd_ptr_ctrl #(.addr_width(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: reads taken so far, write pointer as seen after the two-flop delay
   int m_rd, m_h1, m_h2, m_count;
   bit m_empty, m_valid, m_under;

   function automatic int gray_of(input int n);
      return (n ^ (n >> 1)) & 63;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      assert (obs === exp) else begin
         n_bad = n_bad + 1;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("empty",     32'(bus.empty),       32'(m_empty));
      check("rd_count",  32'(bus.rd_count),    32'(m_count));
      check("rd_addr",   32'(bus.rd_addr),     32'(m_rd % 32));
      check("rd_gray",   32'(bus.rd_ptr_gray), 32'(gray_of(m_rd)));
      check("rd_valid",  32'(bus.rd_valid),    32'(m_valid));
      check("underflow", 32'(bus.underflow),   32'(m_under));
      check("cnt_le_full", 32'(bus.rd_count <= 7'd32), 32'd1);
   endtask

   task automatic model_reset();
      m_rd = 0; m_h1 = 0; m_h2 = 0; m_count = 0;
      m_empty = 1'b1; m_valid = 1'b0; m_under = 1'b0;
   endtask

   task automatic model_edge(input bit ren, input int wbin);
      bit acc;
      acc     = ren && !m_empty;
      m_under = ren && m_empty;
      m_valid = acc;
      m_rd    = (m_rd + int'(acc)) % 64;
      m_count = (m_h2 - m_rd) & 63;
      m_empty = (m_count == 0);
      m_h2    = m_h1;
      m_h1    = wbin & 63;
   endtask

   task automatic step(input bit ren, input int wbin);
      bus.rd_en       = ren;
      bus.wr_ptr_gray = 6'(gray_of(wbin));
      @(posedge clk);
      model_edge(ren, wbin);
      #1;
      check_all();
   endtask

   // Asynchronous reset asserted between edges, held for two edges, released at a falling edge
   task automatic do_reset(input bit ren, input int wbin);
      #2;
      rst_n = 1'b0;
      bus.rd_en       = ren;
      bus.wr_ptr_gray = 6'(gray_of(wbin));
      #1;
      model_reset();
      check_all();
      check("rst_empty", 32'(bus.empty), 32'd1);
      check("rst_valid", 32'(bus.rd_valid), 32'd0);
      repeat (2) begin
         @(posedge clk);
         #1;
         check_all();
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int w, n, vc, uc, e_at, pg, pa;
      bit saw_g, saw_a;
      bus.rd_en = 1'b0;
      bus.wr_ptr_gray = '0;
      model_reset();

      // Reset with a pending write pointer and a read request
      do_reset(1'b1, 2);
      step(1'b1, 2);
      step(1'b1, 2);
      step(1'b1, 2);
      check("t1_empty", 32'(bus.empty), 32'd0);
      check("t1_count", 32'(bus.rd_count), 32'd2);

      // Sync latency of a single write
      do_reset(1'b0, 1);
      step(1'b0, 1);
      check("t2_e1", 32'(bus.empty), 32'd1);
      step(1'b0, 1);
      check("t2_e2", 32'(bus.empty), 32'd1);
      step(1'b0, 1);
      check("t2_e3", 32'(bus.empty), 32'd0);
      check("t2_cnt", 32'(bus.rd_count), 32'd1);

      // Fill to full, then drain past empty
      do_reset(1'b0, 0);
      for (int i = 0; i <= 32; i++) step(1'b0, i);
      n = 0;
      while (bus.rd_count != 6'd32 && n < 8) begin
         step(1'b0, 32);
         n++;
      end
      check("t3_full", 32'(bus.rd_count), 32'd32);
      vc = 0; uc = 0; e_at = -1;
      for (int i = 1; i <= 34; i++) begin
         step(1'b1, 32);
         if (bus.rd_valid) vc++;
         if (bus.underflow) uc++;
         if (bus.empty && e_at < 0) e_at = i;
         if (i == 32) check("t3_cnt0", 32'(bus.rd_count), 32'd0);
      end
      check("t3_valids", 32'(vc), 32'd32);
      check("t3_unders", 32'(uc), 32'd2);
      check("t3_empty_at", 32'(e_at), 32'd32);
      check("t3_addr", 32'(bus.rd_addr), 32'd0);

      // Pointer wrap while reading continuously
      saw_g = 1'b0; saw_a = 1'b0;
      pg = int'(bus.rd_ptr_gray); pa = int'(bus.rd_addr);
      for (int i = 33; i <= 72; i++) begin
         step(1'b1, i % 64);
         if (pg == 32 && bus.rd_ptr_gray == 6'd0) saw_g = 1'b1;
         if (pa == 31 && bus.rd_addr == 5'd0) saw_a = 1'b1;
         pg = int'(bus.rd_ptr_gray); pa = int'(bus.rd_addr);
      end
      repeat (6) step(1'b1, 8);
      check("t4_gray_wrap", 32'(saw_g), 32'd1);
      check("t4_addr_wrap", 32'(saw_a), 32'd1);
      check("t4_drained", 32'(bus.empty), 32'd1);

      // Read accepted on the edge the synced write pointer advances
      repeat (4) step(1'b0, 12);
      check("t5_cnt4", 32'(bus.rd_count), 32'd4);
      step(1'b0, 13);
      step(1'b0, 13);
      step(1'b1, 13);
      check("t5_cnt_hold", 32'(bus.rd_count), 32'd4);
      check("t5_empty", 32'(bus.empty), 32'd0);
      check("t5_valid", 32'(bus.rd_valid), 32'd1);
      step(1'b0, 13);
      check("t5_valid_end", 32'(bus.rd_valid), 32'd0);

      // Reset in the middle of a drain
      for (int i = 14; i <= 28; i++) step(1'b0, i);
      repeat (3) step(1'b0, 28);
      n = 0;
      while (bus.rd_count != 6'd10 && n < 20) begin
         step(1'b1, 28);
         n++;
      end
      check("t6_cnt10", 32'(bus.rd_count), 32'd10);
      do_reset(1'b1, 28);
      step(1'b0, 28);
      check("t6_no_valid", 32'(bus.rd_valid), 32'd0);
      step(1'b0, 28);
      step(1'b0, 28);
      check("t6_resync", 32'(bus.rd_count), 32'd28);

      // Random traffic, writes throttled to the true FIFO capacity
      w = 28;
      for (int i = 0; i < 600; i++) begin
         bit ren;
         ren = 1'($urandom_range(0, 1));
         if (((w - m_rd) & 63) < 32 && $urandom_range(0, 2) != 0) w = (w + 1) & 63;
         step(ren, w);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
